cp0_regfile: RTL and testbench

Coprocessor-0 register file and exception/interrupt controller for the five-stage MIPS pipeline. Takes the writeback stage's CP0 bus and, from it, commits exceptions, services `eret` and `mtc0`, and returns `mfc0` read data to WB in the same cycle. Also runs the Count/Compare timer, samples external interrupts and raises the interrupt request the pipeline converts into an exception. It owns every CP0 state change; WB only requests them.

---
 rtl/cp0_regfile.sv | 153 +++++++++++++++
 tb/tb_cp0_regfile.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile.sv
// CP0 register file and exception/interrupt controller for the MIPS pipeline.
// Define CP0_TIMER_EN to build the Count/Compare timer; without it both read 0.
module cp0_regfile (
    input  logic         clk,
    input  logic         reset,
    input  logic         ws_valid,
    input  logic [109:0] wb_to_cp0_register_bus,
    input  logic [5:0]   ext_int_in,
    output logic [31:0]  cp0_rdata,
    output logic [31:0]  cp0_epc,
    output logic         cp0_status_exl,
    output logic         int_req
);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;
    localparam logic [4:0] EXC_ADEL      = 5'h04;
    localparam logic [4:0] EXC_ADES      = 5'h05;

    logic        ex;
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic        bd;
    logic [31:0] pc;
    logic        mtc0_we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        eret;

    assign {ex, excode, badvaddr, bd, pc, mtc0_we, addr, wdata, eret} = wb_to_cp0_register_bus;

    logic ex_v, eret_v, mtc0_v;
    assign ex_v   = ex & ws_valid;
    assign eret_v = eret & ws_valid & ~ex;
    assign mtc0_v = mtc0_we & ws_valid & ~ex;

    logic [7:0]  im_q;
    logic        exl_q, ie_q;
    logic        bd_q;
    logic [4:0]  exccode_q;
    logic [5:0]  ip_hw_q;
    logic [1:0]  ip_sw_q;
    logic [31:0] epc_q, badvaddr_q;

    logic        timer_int;
    logic [31:0] count_rd, compare_rd;

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, compare_q;
    logic        tick_q, ti_q;
    logic        wr_count, wr_compare;

    assign wr_count   = mtc0_v && (addr == ADDR_COUNT);
    assign wr_compare = mtc0_v && (addr == ADDR_COMPARE);

    // Count advances every other cycle; a Compare write clears TI even on a same-cycle match.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            compare_q <= '0;
            tick_q    <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            tick_q <= ~tick_q;
            if (wr_count)
                count_q <= wdata;
            else if (tick_q)
                count_q <= count_q + 32'd1;
            if (wr_compare)
                compare_q <= wdata;
            if (wr_compare)
                ti_q <= 1'b0;
            else if (count_q == compare_q)
                ti_q <= 1'b1;
        end
    end

    assign timer_int  = ti_q;
    assign count_rd   = count_q;
    assign compare_rd = compare_q;
`else
    assign timer_int  = 1'b0;
    assign count_rd   = '0;
    assign compare_rd = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            exccode_q  <= '0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            ip_hw_q <= {ext_int_in[5] | timer_int, ext_int_in[4:0]};
            if (ex_v) begin
                if (!exl_q) begin
                    epc_q <= bd ? pc - 32'd4 : pc;
                    bd_q  <= bd;
                end
                exl_q     <= 1'b1;
                exccode_q <= excode;
                if (excode == EXC_ADEL || excode == EXC_ADES)
                    badvaddr_q <= badvaddr;
            end else begin
                if (mtc0_v && addr == ADDR_STATUS) begin
                    im_q  <= wdata[15:8];
                    exl_q <= wdata[1];
                    ie_q  <= wdata[0];
                end
                // NOTE: with non-blocking assignments the last one in program order wins,
                // so placing the eret clear after mtc0 gives eret priority on EXL.
                if (eret_v)
                    exl_q <= 1'b0;
                if (mtc0_v && addr == ADDR_CAUSE)
                    ip_sw_q <= wdata[9:8];
                if (mtc0_v && addr == ADDR_EPC)
                    epc_q <= wdata;
            end
        end
    end

    logic [31:0] status_rd, cause_rd;
    assign status_rd = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_rd  = {bd_q, timer_int, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b0};

    // NOTE: the default arm keeps this mux purely combinational (no latch on unlisted addresses).
    always_comb begin
        cp0_rdata = '0;
        case (addr)
            ADDR_BADVADDR: cp0_rdata = badvaddr_q;
            ADDR_COUNT:    cp0_rdata = count_rd;
            ADDR_COMPARE:  cp0_rdata = compare_rd;
            ADDR_STATUS:   cp0_rdata = status_rd;
            ADDR_CAUSE:    cp0_rdata = cause_rd;
            ADDR_EPC:      cp0_rdata = epc_q;
            default:       cp0_rdata = '0;
        endcase
    end

    assign cp0_epc        = epc_q;
    assign cp0_status_exl = exl_q;
    assign int_req        = (|({ip_hw_q, ip_sw_q} & im_q)) & ie_q & ~exl_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed vector table plus hand-written
// reset, timer and timer-less sequences (CP0_TIMER_EN selects the timer checks).
module tb_cp0_regfile;

    logic         clk = 1'b0;
    logic         reset;
    logic         ws_valid;
    logic [109:0] bus;
    logic [5:0]   ext_int_in;
    logic [31:0]  cp0_rdata, cp0_epc;
    logic         cp0_status_exl, int_req;

    logic        b_ex, b_bd, b_we, b_eret;
    logic [4:0]  b_code, b_addr;
    logic [31:0] b_bva, b_pc, b_wdata;

    assign bus = {b_ex, b_code, b_bva, b_bd, b_pc, b_we, b_addr, b_wdata, b_eret};

    cp0_regfile dut (
        .clk                    (clk),
        .reset                  (reset),
        .ws_valid               (ws_valid),
        .wb_to_cp0_register_bus (bus),
        .ext_int_in             (ext_int_in),
        .cp0_rdata              (cp0_rdata),
        .cp0_epc                (cp0_epc),
        .cp0_status_exl         (cp0_status_exl),
        .int_req                (int_req)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        wv, ex;
        logic [4:0]  code;
        logic [31:0] bva;
        logic        bd;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        eret;
        logic [5:0]  ext;
        logic [4:0]  raddr;
        logic [31:0] rexp;
        logic [31:0] epc;
        logic        exl, irq;
    } vec_t;

    function automatic vec_t mk(input string n, input logic wv, input logic ex,
                                input logic [4:0] code, input logic [31:0] bva, input logic bd,
                                input logic [31:0] pc, input logic we, input logic [4:0] addr,
                                input logic [31:0] wdata, input logic eret, input logic [5:0] ext,
                                input logic [4:0] raddr, input logic [31:0] rexp,
                                input logic [31:0] epc, input logic exl, input logic irq);
        vec_t v;
        v.name = n; v.wv = wv; v.ex = ex; v.code = code; v.bva = bva; v.bd = bd; v.pc = pc;
        v.we = we; v.addr = addr; v.wdata = wdata; v.eret = eret; v.ext = ext;
        v.raddr = raddr; v.rexp = rexp; v.epc = epc; v.exl = exl; v.irq = irq;
        return v;
    endfunction

    task automatic idle(input logic [4:0] raddr);
        ws_valid = 1'b0; b_ex = 1'b0; b_code = '0; b_bva = '0; b_bd = 1'b0; b_pc = '0;
        b_we = 1'b0; b_addr = raddr; b_wdata = '0; b_eret = 1'b0;
    endtask

    task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
        b_addr = a;
        #1;
        d = cp0_rdata;
    endtask

    // Called at a negedge; returns at the following negedge with the bus idle.
    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle(a);
        ws_valid = 1'b1; b_we = 1'b1; b_wdata = d;
        @(posedge clk);
        @(negedge clk);
        idle(a);
    endtask

    task automatic run_vec(input vec_t v);
        ws_valid = v.wv; b_ex = v.ex; b_code = v.code; b_bva = v.bva; b_bd = v.bd; b_pc = v.pc;
        b_we = v.we; b_addr = v.addr; b_wdata = v.wdata; b_eret = v.eret; ext_int_in = v.ext;
        @(posedge clk);
        @(negedge clk);
        idle(v.raddr);
        #1;
        check({v.name, "_rdata"}, cp0_rdata, v.rexp);
        check({v.name, "_epc"}, cp0_epc, v.epc);
        check({v.name, "_exl"}, {31'b0, cp0_status_exl}, {31'b0, v.exl});
        check({v.name, "_irq"}, {31'b0, int_req}, {31'b0, v.irq});
    endtask

    vec_t vecs[24];
    logic [31:0] rd;

    initial begin
        //                  name             wv ex code   badvaddr      bd pc            we addr   wdata         er ext        raddr  rexp          epc           exl irq
        vecs[0]  = mk("disarm_timer",     1, 0, 5'h00, 32'h0,        0, 32'h0,        1, 5'd11, 32'hFFFF0000, 0, 6'b000000, 5'd12, 32'h00400000, 32'h0,        0, 0);
        vecs[1]  = mk("idle_cause",       0, 0, 5'h00, 32'h0,        0, 32'h0,        0, 5'd0,  32'h0,        0, 6'b000000, 5'd13, 32'h00000000, 32'h0,        0, 0);
        vecs[2]  = mk("ex_adel",          1, 1, 5'h04, 32'h12345673, 1, 32'hBFC00100, 0, 5'd0,  32'h0,        0, 6'b000000, 5'd13, 32'h80000010, 32'hBFC000FC, 1, 0);
        vecs[3]  = mk("ex_badvaddr",      0, 0, 5'h00, 32'h0,        0, 32'h0,        0, 5'd0,  32'h0,        0, 6'b000000, 5'd8,  32'h12345673, 32'hBFC000FC, 1, 0);
        vecs[4]  = mk("ex_nested",        1, 1, 5'h05, 32'hDEAD0001, 0, 32'h80000000, 0, 5'd0,  32'h0,        0, 6'b000000, 5'd13, 32'h80000014, 32'hBFC000FC, 1, 0);
        vecs[5]  = mk("nested_bva",       0, 0, 5'h00, 32'h0,        0, 32'h0,        0, 5'd0,  32'h0,        0, 6'b000000, 5'd8,  32'hDEAD0001, 32'hBFC000FC, 1, 0);
        vecs[6]  = mk("ex_no_bva",        1, 1, 5'h0A, 32'h55555555, 0, 32'h80000010, 0, 5'd0,  32'h0,        0, 6'b000000, 5'd8,  32'hDEAD0001, 32'hBFC000FC, 1, 0);
        vecs[7]  = mk("eret",             1, 0, 5'h00, 32'h0,        0, 32'h0,        0, 5'd0,  32'h0,        1, 6'b000000, 5'd12, 32'h00400000, 32'hBFC000FC, 0, 0);
        vecs[8]  = mk("status_all_ones",  1, 0, 5'h00, 32'h0,        0, 32'h0,        1, 5'd12, 32'hFFFFFFFF, 0, 6'b000000, 5'd12, 32'h0040FF03, 32'hBFC000FC, 1, 0);
        vecs[9]  = mk("status_8001",      1, 0, 5'h00, 32'h0,        0, 32'h0,        1, 5'd12, 32'h00008001, 0, 6'b000000, 5'd12, 32'h00408001, 32'hBFC000FC, 0, 0);
        vecs[10] = mk("cause_write_mask", 1, 0, 5'h00, 32'h0,        0, 32'h0,        1, 5'd13, 32'hFFFFFFFF, 0, 6'b000000, 5'd13, 32'h80000328, 32'hBFC000FC, 0, 0);
        vecs[11] = mk("badvaddr_ro",      1, 0, 5'h00, 32'h0,        0, 32'h0,        1, 5'd8,  32'h00000000, 0, 6'b000000, 5'd8,  32'hDEAD0001, 32'hBFC000FC, 0, 0);
        vecs[12] = mk("mtc0_epc",         1, 0, 5'h00, 32'h0,        0, 32'h0,        1, 5'd14, 32'h00001000, 0, 6'b000000, 5'd14, 32'h00001000, 32'h00001000, 0, 0);
        vecs[13] = mk("unimpl_addr",      1, 0, 5'h00, 32'h0,        0, 32'h0,        1, 5'd3,  32'h12345678, 0, 6'b000000, 5'd3,  32'h00000000, 32'h00001000, 0, 0);
        vecs[14] = mk("ext_int7",         0, 0, 5'h00, 32'h0,        0, 32'h0,        0, 5'd0,  32'h0,        0, 6'b100000, 5'd13, 32'h80008328, 32'h00001000, 0, 1);
        vecs[15] = mk("ex_masks_irq",     1, 1, 5'h00, 32'h0,        0, 32'h80000180, 0, 5'd0,  32'h0,        0, 6'b100000, 5'd13, 32'h00008300, 32'h80000180, 1, 0);
        vecs[16] = mk("eret_unmasks",     1, 0, 5'h00, 32'h0,        0, 32'h0,        0, 5'd0,  32'h0,        1, 6'b100000, 5'd12, 32'h00408001, 32'h80000180, 0, 1);
        vecs[17] = mk("ext_drop",         0, 0, 5'h00, 32'h0,        0, 32'h0,        0, 5'd0,  32'h0,        0, 6'b000000, 5'd13, 32'h00000300, 32'h80000180, 0, 0);
        vecs[18] = mk("sw_int",           1, 0, 5'h00, 32'h0,        0, 32'h0,        1, 5'd12, 32'h00000101, 0, 6'b000000, 5'd12, 32'h00400101, 32'h80000180, 0, 1);
        vecs[19] = mk("prio_all",         1, 1, 5'h08, 32'h0,        0, 32'h80001234, 1, 5'd14, 32'hDEADBEEF, 1, 6'b000000, 5'd14, 32'h80001234, 32'h80001234, 1, 0);
        vecs[20] = mk("no_valid",         0, 1, 5'h04, 32'hAAAA0000, 1, 32'h11111111, 1, 5'd14, 32'hCAFEF00D, 1, 6'b000000, 5'd13, 32'h00000320, 32'h80001234, 1, 0);
        vecs[21] = mk("eret_over_mtc0",   1, 0, 5'h00, 32'h0,        0, 32'h0,        1, 5'd12, 32'h00000003, 1, 6'b000000, 5'd12, 32'h00400001, 32'h80001234, 0, 0);
        vecs[22] = mk("cause_clear_sw",   1, 0, 5'h00, 32'h0,        0, 32'h0,        1, 5'd13, 32'h00000000, 0, 6'b000000, 5'd13, 32'h00000020, 32'h80001234, 0, 0);
        vecs[23] = mk("ex_bd_epc",        1, 1, 5'h0C, 32'h0,        1, 32'h00400000, 0, 5'd0,  32'h0,        0, 6'b000000, 5'd13, 32'h80000030, 32'h003FFFFC, 1, 0);

        // Reset wins over a same-cycle exception request.
        reset = 1'b1;
        ext_int_in = '0;
        idle(5'd12);
        ws_valid = 1'b1; b_ex = 1'b1; b_pc = 32'h12340000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(5'd12);
        #1;
        check("rst_epc", cp0_epc, 32'h0);
        check("rst_exl", {31'b0, cp0_status_exl}, 32'h0);
        check("rst_irq", {31'b0, int_req}, 32'h0);
        check("rst_status", cp0_rdata, 32'h00400000);
        read_reg(5'd13, rd); check("rst_cause", rd, 32'h0);
        read_reg(5'd8, rd);  check("rst_badvaddr", rd, 32'h0);
        read_reg(5'd11, rd); check("rst_compare", rd, 32'h0);

        repeat (10) @(posedge clk);
        @(negedge clk);
        read_reg(5'd9, rd);
`ifdef CP0_TIMER_EN
        check("idle_count", rd, 32'd5);
`else
        check("idle_count", rd, 32'd0);
`endif
        read_reg(5'd12, rd); check("idle_status", rd, 32'h00400000);
        check("idle_irq", {31'b0, int_req}, 32'h0);

        // ext interrupt is invisible to int_req until IP7 has been registered.
        @(negedge clk);
        for (int i = 0; i < 24; i++) run_vec(vecs[i]);

`ifdef CP0_TIMER_EN
        begin
            bit found;
            mtc0(5'd9, 32'h0000000E);
            mtc0(5'd11, 32'h00000010);
            found = 1'b0;
            for (int i = 0; i < 12 && !found; i++) begin
                read_reg(5'd9, rd);
                if (rd == 32'h10) found = 1'b1;
                else begin @(posedge clk); @(negedge clk); end
            end
            check("count_reach_0x10", {31'b0, found}, 32'h1);
            read_reg(5'd13, rd); check("ti_before_match_edge", {31'b0, rd[30]}, 32'h0);
            @(posedge clk); @(negedge clk);
            read_reg(5'd13, rd); check("ti_set", {31'b0, rd[30]}, 32'h1);
            @(posedge clk); @(negedge clk);
            read_reg(5'd13, rd); check("ip7_from_ti", {31'b0, rd[15]}, 32'h1);

            mtc0(5'd9, 32'hFFFFFFFF);
            found = 1'b0;
            for (int i = 0; i < 4 && !found; i++) begin
                read_reg(5'd9, rd);
                if (rd != 32'hFFFFFFFF) found = 1'b1;
                else begin @(posedge clk); @(negedge clk); end
            end
            check("count_wrap", rd, 32'h0);

            mtc0(5'd9, 32'h0000002E);
            mtc0(5'd11, 32'h00000030);
            read_reg(5'd13, rd); check("ti_cleared_by_compare", {31'b0, rd[30]}, 32'h0);
            found = 1'b0;
            for (int i = 0; i < 12 && !found; i++) begin
                read_reg(5'd9, rd);
                if (rd == 32'h30) found = 1'b1;
                else begin @(posedge clk); @(negedge clk); end
            end
            check("count_reach_0x30", {31'b0, found}, 32'h1);
            mtc0(5'd11, 32'h00000100);
            read_reg(5'd13, rd); check("clear_wins_ti", {31'b0, rd[30]}, 32'h0);
            read_reg(5'd11, rd); check("compare_readback", rd, 32'h00000100);
            @(posedge clk); @(negedge clk);
            read_reg(5'd13, rd); check("clear_wins_ti_hold", {31'b0, rd[30]}, 32'h0);
        end
`else
        mtc0(5'd9, 32'd5);
        read_reg(5'd9, rd);  check("no_timer_count", rd, 32'h0);
        mtc0(5'd11, 32'h0);
        repeat (3) begin @(posedge clk); @(negedge clk); end
        read_reg(5'd13, rd); check("no_timer_ti", rd & 32'h40008000, 32'h0);
        read_reg(5'd11, rd); check("no_timer_compare", rd, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
